// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for a 32-bit ALU datapath; owns PC and flags F1/F2.
// Optional: define ALU_SEQ_ILLEGAL_TRAP_EN to halt on illegal opcodes and expose the illegal_op output.
module alu_sequencer #(
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [6:0]    HALT_OP  = 7'd127
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_data,
  output logic [4:0]    rf_ra,
  output logic [4:0]    rf_rb,
  output logic [4:0]    rf_rd,
  output logic          rf_we,
  output logic          alu_en,
  output logic [6:0]    alu_op,
  output logic [15:0]   alu_imm,
  output logic          alu_highlow,
  input  logic          alu_flag,
  input  logic [AW-1:0] branch_target,
  output logic          flag1,
  output logic          flag2,
  output logic [AW-1:0] pc,
  output logic          halted
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic          illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_FLAG,
    C_BRANCH,
    C_HALT,
    C_ILLEGAL
  } op_class_e;

  // HALT_OP is tested first so a parameter override can never be shadowed by another class.
  function automatic op_class_e classify(input logic [6:0] op);
    if (op == HALT_OP)     return C_HALT;
    else if (op <= 7'd7)   return C_ALU;
    else if (op <= 7'd13)  return C_FLAG;
    else if (op == 7'd14)  return C_BRANCH;
    else                   return C_ILLEGAL;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic          flag1_q, flag1_d;
  logic          flag2_q, flag2_d;
  logic          flag_smp_q, flag_smp_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic          illegal_q, illegal_d;
`endif
  op_class_e     op_class;

  assign op_class = classify(ir_q[31:25]);

  // Decoded fields come straight from the instruction register, so they are
  // valid from DECODE and hold until the next fetch is acknowledged.
  assign alu_op      = ir_q[31:25];
  assign rf_rd       = ir_q[24:20];
  assign rf_ra       = ir_q[19:15];
  assign rf_rb       = ir_q[14:10];
  assign alu_imm     = ir_q[15:0];
  assign alu_highlow = (ir_q[31:25] == 7'd6);

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flag1     = flag1_q;
  assign flag2     = flag2_q;
  assign halted    = (state_q == S_HALT);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flag1_d    = flag1_q;
    flag2_d    = flag2_q;
    flag_smp_d = flag_smp_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    imem_req   = 1'b0;
    alu_en     = 1'b0;
    rf_we      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op_class == C_HALT) begin
          state_d = S_HALT;
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        else if (op_class == C_ILLEGAL) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
`endif
        else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_en     = (op_class != C_ILLEGAL);
        flag_smp_d = alu_flag;
        state_d    = S_WB;
      end

      S_WB: begin
        rf_we = (op_class == C_ALU);
        if (op_class == C_FLAG) begin
          flag2_d = flag1_q;
          flag1_d = flag_smp_q;
        end
        if (op_class == C_BRANCH && flag1_q) pc_d = branch_target;
        else                                 pc_d = pc_q + AW'(1);
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      flag1_q    <= 1'b0;
      flag2_q    <= 1'b0;
      flag_smp_q <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      flag1_q    <= flag1_d;
      flag2_q    <= flag2_d;
      flag_smp_q <= flag_smp_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  // Strobes are decoded from mutually exclusive states; these guard that structure.
  a_strobe_exclusive: assert property (@(posedge clock) !(rf_we && alu_en));
  a_halt_quiet: assert property (@(posedge clock) halted |-> !(rf_we || alu_en || imem_req));

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an ISA-level model predicts fetch/execute/writeback
// events with their cycle times; a monitor pops and compares whenever the DUT strobes.
module tb_alu_sequencer;

  localparam int unsigned   AW       = 16;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_data = '0;
  logic [4:0]    rf_ra, rf_rb, rf_rd;
  logic          rf_we, alu_en;
  logic [6:0]    alu_op;
  logic [15:0]   alu_imm;
  logic          alu_highlow;
  logic          alu_flag = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          flag1, flag2;
  logic [AW-1:0] pc;
  logic          halted;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic          illegal_op;
`endif

  alu_sequencer #(.AW(AW), .RESET_PC(RESET_PC), .HALT_OP(7'd127)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .rf_ra        (rf_ra),
    .rf_rb        (rf_rb),
    .rf_rd        (rf_rd),
    .rf_we        (rf_we),
    .alu_en       (alu_en),
    .alu_op       (alu_op),
    .alu_imm      (alu_imm),
    .alu_highlow  (alu_highlow),
    .alu_flag     (alu_flag),
    .branch_target(branch_target),
    .flag1        (flag1),
    .flag2        (flag2),
    .pc           (pc),
    .halted       (halted)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  always #5 clock = ~clock;

  typedef enum int {EV_FETCH, EV_EXEC, EV_WB} ev_kind_e;

  typedef struct {
    ev_kind_e      kind;
    int            cyc;
    logic [AW-1:0] addr;
    logic          f1;
    logic          f2;
    logic [6:0]    op;
    logic [4:0]    rd;
    logic [4:0]    ra;
    logic [4:0]    rb;
    logic [15:0]   imm;
    logic          hl;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Architectural model state
  logic [AW-1:0] m_pc;
  logic          m_f1, m_f2, m_halted, m_illegal;
  int            last_ack_cyc;
  bit            last_valid;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 10'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [15:0] imm);
    return {op, rd, 4'd0, imm};
  endfunction

  // Instruction-level semantics: predicts the visible events and updates PC/flags.
  task automatic model_issue(input logic [31:0] w, input logic fl, input logic [AW-1:0] bt);
    ev_t        e;
    logic [6:0] op;
    op     = w[31:25];
    e.kind = EV_FETCH;
    e.cyc  = cyc;
    e.addr = m_pc;
    e.f1   = m_f1;
    e.f2   = m_f2;
    e.op   = op;
    e.rd   = w[24:20];
    e.ra   = w[19:15];
    e.rb   = w[14:10];
    e.imm  = w[15:0];
    e.hl   = (op == 7'd6);
    exp_q.push_back(e);
    if (op == 7'd127) begin
      m_halted = 1'b1;
    end else if (op <= 7'd14) begin
      e.kind = EV_EXEC;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
      if (op <= 7'd7) begin
        e.kind = EV_WB;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
        m_pc = m_pc + 1'b1;
      end else if (op <= 7'd13) begin
        m_f2 = m_f1;
        m_f1 = fl;
        m_pc = m_pc + 1'b1;
      end else begin
        m_pc = m_f1 ? bt : m_pc + 1'b1;
      end
    end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      m_halted  = 1'b1;
      m_illegal = 1'b1;
`else
      m_pc = m_pc + 1'b1;
`endif
    end
  endtask

  task automatic expect_ev(input ev_kind_e k);
    ev_t e;
    check("event_expected", (exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    check("event_cycle", cyc, e.cyc);
    case (k)
      EV_FETCH: begin
        check("fetch_addr", imem_addr, e.addr);
        check("fetch_flag1", flag1, e.f1);
        check("fetch_flag2", flag2, e.f2);
      end
      EV_EXEC: begin
        check("exec_op", alu_op, e.op);
        check("exec_ra", rf_ra, e.ra);
        check("exec_rb", rf_rb, e.rb);
        check("exec_imm", alu_imm, e.imm);
        check("exec_highlow", alu_highlow, e.hl);
      end
      default: begin
        check("wb_rd", rf_rd, e.rd);
        check("wb_ra", rf_ra, e.ra);
        check("wb_rb", rf_rb, e.rb);
        check("wb_op", alu_op, e.op);
        check("wb_imm", alu_imm, e.imm);
        check("wb_highlow", alu_highlow, e.hl);
      end
    endcase
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("strobe_overlap", (alu_en & rf_we), 0);
      check("halted_quiet", (halted & (alu_en | rf_we | imem_req)), 0);
      if (imem_req && imem_ack) expect_ev(EV_FETCH);
      if (alu_en) expect_ev(EV_EXEC);
      if (rf_we) expect_ev(EV_WB);
    end
  end

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    ok = imem_req;
    if (!ok) check("fetch_req_timeout", imem_req, 1);
  endtask

  task automatic fetch(input logic [31:0] w, input logic fl, input logic [AW-1:0] bt,
                       input int waits);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (waits) begin
      @(posedge clock); #1;
    end
    if (last_valid) check("fetch_interval", cyc - last_ack_cyc, 4 + waits);
    imem_data     = w;
    imem_ack      = 1'b1;
    alu_flag      = fl;
    branch_target = bt;
    model_issue(w, fl, bt);
    last_ack_cyc  = cyc;
    last_valid    = 1'b1;
    @(posedge clock); #1;
    imem_ack  = 1'b0;
    imem_data = $urandom();
  endtask

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_f1       = 1'b0;
    m_f2       = 1'b0;
    m_halted   = 1'b0;
    m_illegal  = 1'b0;
    last_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    imem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_flag1"}, flag1, 0);
    check({tag, "_flag2"}, flag2, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_imem_req"}, imem_req, 1);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_alu_en"}, alu_en, 0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    check({tag, "_illegal_op"}, illegal_op, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    model_reset();

    do_reset();
    check_reset_state("reset");
    check("reset_alu_op", alu_op, 0);
    check("reset_rf_rd", rf_rd, 0);
    check("reset_highlow", alu_highlow, 0);

    // Directed: add, load-high, flag then branch taken / not taken
    fetch(mk_r(7'd0, 5'd3, 5'd1, 5'd2), 1'b0, 16'h0000, 0);
    fetch(mk_i(7'd6, 5'd2, 16'hBEEF), 1'b0, 16'h0000, 0);
    fetch(mk_r(7'd8, 5'd0, 5'd4, 5'd5), 1'b1, 16'h0000, 0);
    fetch(mk_r(7'd14, 5'd0, 5'd0, 5'd0), 1'b0, 16'h0040, 0);
    fetch(mk_r(7'd8, 5'd0, 5'd4, 5'd5), 1'b0, 16'h0000, 1);
    fetch(mk_r(7'd14, 5'd0, 5'd0, 5'd0), 1'b1, 16'h1234, 0);

    // Branch to the top of the address space, then wrap on the next increment
    fetch(mk_r(7'd9, 5'd0, 5'd1, 5'd1), 1'b1, 16'h0000, 0);
    fetch(mk_r(7'd14, 5'd0, 5'd0, 5'd0), 1'b0, 16'hFFFF, 0);
    fetch(mk_r(7'd0, 5'd7, 5'd6, 5'd5), 1'b0, 16'h0000, 2);
    fetch(mk_r(7'd10, 5'd0, 5'd1, 5'd2), 1'b1, 16'h0000, 0);
    wait_req(ok);
    check("wrap_pc", pc, m_pc);

    // Reset in the second wait cycle of a fetch; the ack in the reset cycle is dropped
    check("pre_reset_flags", {flag2, flag1}, 2'b11);
    @(posedge clock); #1;
    reset     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = mk_r(7'd0, 5'd9, 5'd9, 5'd9);
    @(posedge clock); #1;
    reset    = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    check("midreset_queue", exp_q.size(), 0);
    check_reset_state("midreset");
    repeat (4) begin
      @(posedge clock); #1;
    end
    check("midreset_pc_hold", pc, RESET_PC);
    fetch(mk_r(7'd1, 5'd4, 5'd2, 5'd3), 1'b0, 16'h0000, 0);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      int          r;
      logic [6:0]  op;
      logic [31:0] rnd;
      r = $urandom_range(0, 19);
      if (r < 10)      op = 7'($urandom_range(0, 7));
      else if (r < 15) op = 7'($urandom_range(8, 13));
      else if (r < 18) op = 7'd14;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      else             op = 7'($urandom_range(0, 7));
`else
      else             op = 7'($urandom_range(15, 126));
`endif
      rnd = $urandom();
      fetch({op, rnd[24:0]}, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 65535)),
            $urandom_range(0, 3));
    end

    // Illegal opcode 20
    fetch(mk_r(7'd20, 5'd1, 5'd2, 5'd3), 1'b0, 16'h0000, 0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    @(posedge clock); #1;
    check("trap_halted", halted, 1);
    check("trap_illegal_op", illegal_op, 1);
    check("trap_pc", pc, m_pc);
    check("trap_imem_req", imem_req, 0);
    do_reset();
    check_reset_state("trap_reset");
`else
    fetch(mk_r(7'd0, 5'd1, 5'd1, 5'd1), 1'b0, 16'h0000, 0);
`endif

    // Halt and stay halted
    fetch(mk_r(7'd2, 5'd5, 5'd6, 5'd7), 1'b0, 16'h0000, 0);
    fetch(mk_r(7'd127, 5'd0, 5'd0, 5'd0), 1'b0, 16'h0000, 0);
    @(posedge clock); #1;
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", halted, 1);
      check("halt_imem_req", imem_req, 0);
      check("halt_pc", pc, m_pc);
      @(posedge clock); #1;
    end

    check("events_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
